// File: rtl/ram_512x8.sv
// 512-byte big-endian RAM with a 4-phase mfa/moc handshake and a configurable access latency.
// Misaligned or reserved-size requests complete immediately with align_err set.
module ram_512x8 #(
  parameter int unsigned LATENCY = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mfa,
  input  logic        rw,
  input  logic [1:0]  size,
  input  logic [8:0]  address,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        moc,
  output logic        align_err
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [3:0] CNT_LOAD  = 4'(LATENCY - 1);
  localparam bit         SKIP_BUSY = (LATENCY == 1);

  state_t      r_state, w_state_next;
  logic [3:0]  r_cnt, w_cnt_next;
  logic        r_moc, w_moc_next;
  logic        r_aerr, w_aerr_next;
  logic [31:0] r_data_out;

  logic        r_rw;
  logic [1:0]  r_size;
  logic [8:0]  r_addr;
  logic [31:0] r_din;

  logic [7:0]  r_mem [512];

  logic        w_capture;
  logic        w_bad;
  logic        w_fire;
  logic        w_op_rw;
  logic [1:0]  w_op_size;
  logic [8:0]  w_op_addr;
  logic [31:0] w_op_din;
  logic [8:0]  w_a1, w_a2, w_a3;
  logic [31:0] w_rd_word;

  function automatic logic f_misaligned(input logic [1:0] s, input logic [8:0] a);
    return (s == 2'b11) || (s == 2'b01 && a[0]) || (s == 2'b10 && a[1:0] != 2'b00);
  endfunction

  assign w_capture = (r_state == IDLE) && mfa;

  // With LATENCY=1 the access happens on the capture edge, so it must use the live inputs.
  assign w_op_rw   = (r_state == IDLE) ? rw      : r_rw;
  assign w_op_size = (r_state == IDLE) ? size    : r_size;
  assign w_op_addr = (r_state == IDLE) ? address : r_addr;
  assign w_op_din  = (r_state == IDLE) ? data_in : r_din;

  assign w_bad = f_misaligned(w_op_size, w_op_addr);

  assign w_fire = reset_n &&
                  ((w_capture && !w_bad && SKIP_BUSY) ||
                   (r_state == BUSY && r_cnt == 4'd0));

  // Aligned accesses never cross the alignment boundary, so offsets are bit substitutions.
  assign w_a1 = {w_op_addr[8:1], 1'b1};
  assign w_a2 = {w_op_addr[8:2], 2'b10};
  assign w_a3 = {w_op_addr[8:2], 2'b11};

  always_comb begin
    w_rd_word = 32'd0;
    case (w_op_size)
      2'b00:   w_rd_word = {24'd0, r_mem[w_op_addr]};
      2'b01:   w_rd_word = {16'd0, r_mem[w_op_addr], r_mem[w_a1]};
      2'b10:   w_rd_word = {r_mem[w_op_addr], r_mem[w_a1], r_mem[w_a2], r_mem[w_a3]};
      default: w_rd_word = 32'd0;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_moc_next   = r_moc;
    w_aerr_next  = r_aerr;
    case (r_state)
      IDLE: begin
        if (mfa) begin
          if (w_bad) begin
            w_state_next = DONE;
            w_moc_next   = 1'b1;
            w_aerr_next  = 1'b1;
          end else if (SKIP_BUSY) begin
            w_state_next = DONE;
            w_moc_next   = 1'b1;
            w_aerr_next  = 1'b0;
          end else begin
            w_state_next = BUSY;
            w_cnt_next   = CNT_LOAD;
          end
        end
      end
      BUSY: begin
        if (r_cnt == 4'd0) begin
          w_state_next = DONE;
          w_moc_next   = 1'b1;
          w_aerr_next  = 1'b0;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      DONE: begin
        if (!mfa) begin
          w_state_next = IDLE;
          w_moc_next   = 1'b0;
          w_aerr_next  = 1'b0;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_moc_next   = 1'b0;
        w_aerr_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_cnt      <= 4'd0;
      r_moc      <= 1'b0;
      r_aerr     <= 1'b0;
      r_data_out <= 32'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_moc   <= w_moc_next;
      r_aerr  <= w_aerr_next;
      if (w_fire && w_op_rw) r_data_out <= w_rd_word;
    end
  end

  // Request fields and storage carry no reset; memory contents survive reset.
  always_ff @(posedge clk) begin
    if (w_capture) begin
      r_rw   <= rw;
      r_size <= size;
      r_addr <= address;
      r_din  <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (w_fire && !w_op_rw) begin
      case (w_op_size)
        2'b00: r_mem[w_op_addr] <= w_op_din[7:0];
        2'b01: begin
          r_mem[w_op_addr] <= w_op_din[15:8];
          r_mem[w_a1]      <= w_op_din[7:0];
        end
        2'b10: begin
          r_mem[w_op_addr] <= w_op_din[31:24];
          r_mem[w_a1]      <= w_op_din[23:16];
          r_mem[w_a2]      <= w_op_din[15:8];
          r_mem[w_a3]      <= w_op_din[7:0];
        end
        default: ;
      endcase
    end
  end

  assign data_out  = r_data_out;
  assign moc       = r_moc;
  assign align_err = r_aerr;

endmodule

// File: doc/ram_512x8.md
RAM_512X8 -- requirements
Module: ram_512x8

Interface
REQ-001 The block SHALL have parameter LATENCY, default 3, meaning cycles from request capture to moc assertion (legal 1..15).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 mfa  input  1  memory function active; request/hold line of a 4-phase handshake.
REQ-005 rw  input  1  1 = read, 0 = write.
REQ-006 size  input  2  00 byte, 01 halfword, 10 word, 11 reserved.
REQ-007 address  input  9  byte address, driven by the MAR-side mux.
REQ-008 data_in  input  32  write data from MDR; right-justified for byte and halfword.
REQ-009 data_out  output  32  read data to MDR-side mux, registered.
REQ-010 moc  output  1  memory operation complete, registered.
REQ-011 align_err  output  1  request rejected as misaligned or reserved size, registered.

Function
REQ-012 Storage SHALL be 512 bytes, big-endian: byte at address a is the most significant byte of the halfword or word starting at a.
REQ-013 FSM states SHALL be IDLE, BUSY, DONE.
REQ-014 IDLE with mfa=1 at a rising edge SHALL capture rw, size, address, data_in; input changes after capture are ignored until the next request.
REQ-015 Misaligned requests SHALL be rejected: halfword with address[0]=1, word with address[1:0]!=00, or size=11.
REQ-016 A rejected capture SHALL go directly to DONE with moc=1 and align_err=1 after that same edge; no memory write; data_out unchanged.
REQ-017 A valid capture SHALL go to BUSY and load a down-counter so moc rises on exactly the LATENCY-th rising edge after the capture edge.
REQ-018 LATENCY=1 SHALL skip BUSY; the valid capture goes directly to DONE.
REQ-019 The write, or the data_out update for a read, SHALL occur on the edge that enters DONE; align_err=0 on that edge.
REQ-020 Word write: mem[a..a+3] = data_in[31:24], [23:16], [15:8], [7:0].
REQ-021 Halfword write: mem[a] = data_in[15:8], mem[a+1] = data_in[7:0].
REQ-022 Byte write: mem[a] = data_in[7:0].
REQ-023 Reads SHALL return the same byte mapping, zero-extended to 32 bits for byte and halfword; sign extension is outside this block.
REQ-024 data_out SHALL hold its value until the next successful read completes; writes and rejected requests do not change it.
REQ-025 DONE SHALL hold moc=1 and align_err while mfa=1; mfa=0 at an edge returns to IDLE with moc=0 and align_err=0.
REQ-026 A new request SHALL need mfa low for at least one edge after DONE; mfa held high across DONE never starts a second operation.
REQ-027 mfa dropping during BUSY SHALL NOT abort the operation; it completes, moc pulses for one cycle in DONE, then the FSM returns to IDLE.
REQ-028 Aligned accesses never wrap; a word at 0x1FC covers bytes 0x1FC..0x1FF.

Reset
REQ-029 reset_n=0 SHALL immediately, without waiting for clk, force state IDLE, moc=0, align_err=0, data_out=0, counter=0.
REQ-030 Reset SHALL NOT alter memory contents; a write whose DONE-entry edge has not occurred when reset asserts SHALL NOT be performed.
REQ-031 After reset_n rises, the first edge with mfa=1 in IDLE SHALL be accepted as a new request.

Verification (LATENCY=3 unless stated)
REQ-032 Word write 0xDEADBEEF @0x010, handshake complete, then byte reads @0x010..0x013 -> data_out 0xDE, 0xAD, 0xBE, 0xEF in turn; moc 3 edges after each capture.
REQ-033 Halfword write 0x1234 @0x1FE, then word read @0x1FC -> data_out[15:0]=0x1234, upper bytes equal prior contents; no wrap.
REQ-034 Word read @0x002 -> moc=1 and align_err=1 one edge after capture; data_out and memory unchanged; mfa=0 -> both clear next edge.
REQ-035 Word write 0xCAFEF00D @0x020, reset_n pulsed low in BUSY, then word read @0x020 -> old contents returned; moc=0 and data_out=0 during reset.
REQ-036 Read with mfa held high 10 cycles -> moc high from edge 3 until one edge after mfa falls; exactly one memory access.
REQ-037 LATENCY=1, byte read @0x000 -> moc after the capture edge; mfa dropped in BUSY (LATENCY=3) -> one-cycle moc pulse, then IDLE.
